// File: rtl/core_bus_bridge_pkg.sv
// rtl/core_bus_bridge_pkg.sv - shared bus types and constants for core_bus_bridge
package core_bus_bridge_pkg;

  typedef logic [2:0]  msize_t;
  typedef logic [3:0]  mlen_t;
  typedef logic [1:0]  axi_burst_t;
  typedef logic [31:0] addr_t;
  typedef logic [7:0]  strobe_t;
  typedef logic [1:0]  bridge_state_t;

  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;

  localparam mlen_t MLEN1 = 4'd0;

  localparam axi_burst_t AXI_BURST_FIXED = 2'd0;

  localparam bridge_state_t IDLE  = 2'd0;
  localparam bridge_state_t ISSUE = 2'd1;
  localparam bridge_state_t DONE  = 2'd2;

  // Port identifiers used by the arbiter and the response steering.
  localparam logic SEL_IBUS = 1'b0;
  localparam logic SEL_DBUS = 1'b1;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    addr_t       addr;
    msize_t      size;
    strobe_t     strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    addr_t       addr;
    strobe_t     strobe;
    logic [63:0] data;
    mlen_t       len;
    axi_burst_t  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  // Instruction fetches are 32-bit: address bit 2 selects the half of the 64-bit beat.
  function automatic logic [31:0] pick_word(input logic [63:0] beat, input logic hi);
    return hi ? beat[63:32] : beat[31:0];
  endfunction

endpackage

// File: rtl/core_bus_bridge_arb.sv
// rtl/core_bus_bridge_arb.sv - two-way round-robin arbiter between ibus and dbus
module rr_arbiter2
  import core_bus_bridge_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic       o_grant
);

  logic r_last;

  // A lone requester always wins; on a tie the port that did not win the last tie goes.
  always_comb begin
    if (i_req == 2'b11) begin
      o_grant = ~r_last;
    end else begin
      o_grant = i_req[1];
    end
  end

  // Only ties move the round-robin pointer; ibus is treated as the previous winner after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last <= SEL_IBUS;
    end else if (i_update && (&i_req)) begin
      r_last <= o_grant;
    end
  end

endmodule

// File: rtl/core_bus_bridge.sv
// rtl/core_bus_bridge.sv - single-outstanding bridge from core ibus/dbus to cbus
module core_bus_bridge
  import core_bus_bridge_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
);

  bridge_state_t r_state;
  cbus_req_t     r_req;
  logic          r_sel;
  logic [63:0]   r_data;

  logic      w_idle;
  logic      w_any;
  logic      w_grant;
  cbus_req_t w_next_req;

  assign w_idle = (r_state == IDLE);
  assign w_any  = ireq.valid | dreq.valid;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_req    ({dreq.valid, ireq.valid}),
    .i_update (w_idle & w_any),
    .o_grant  (w_grant)
  );

  // Shape the winning request into a single-beat cbus transaction ready to be latched.
  always_comb begin
    w_next_req       = '0;
    w_next_req.valid = 1'b1;
    w_next_req.len   = MLEN1;
    w_next_req.burst = AXI_BURST_FIXED;
    if (w_grant == SEL_DBUS) begin
      w_next_req.is_write = |dreq.strobe;
      w_next_req.size     = dreq.size;
      w_next_req.addr     = dreq.addr;
      w_next_req.strobe   = dreq.strobe;
      w_next_req.data     = dreq.data;
    end else begin
      w_next_req.size = MSIZE4;
      w_next_req.addr = ireq.addr;
    end
  end

  // IDLE latches one request, ISSUE waits for the final beat, DONE returns the response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_req   <= '0;
      r_sel   <= SEL_IBUS;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_req   <= w_next_req;
            r_sel   <= w_grant;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (cresp.ready && cresp.last) begin
            r_data  <= cresp.data;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // cbus is driven only while issuing; a requester that let go of valid gets no pulse.
  always_comb begin
    creq  = '0;
    iresp = '0;
    dresp = '0;
    if (r_state == ISSUE) begin
      creq = r_req;
    end
    if (r_state == DONE) begin
      if (r_sel == SEL_DBUS) begin
        dresp.addr_ok = dreq.valid;
        dresp.data_ok = dreq.valid;
        dresp.data    = r_data;
      end else begin
        iresp.addr_ok = ireq.valid;
        iresp.data_ok = ireq.valid;
        iresp.data    = pick_word(r_data, r_req.addr[2]);
      end
    end
  end

endmodule

// File: tb/tb_core_bus_bridge.sv
// tb/tb_core_bus_bridge.sv - randomized scoreboard bench for core_bus_bridge
module tb_core_bus_bridge;
  import core_bus_bridge_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  core_bus_bridge dut (
    .clk   (clk),
    .reset (reset),
    .ireq  (ireq),
    .iresp (iresp),
    .dreq  (dreq),
    .dresp (dresp),
    .creq  (creq),
    .cresp (cresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t      sbq[$];
  int        n_tests = 0;
  int        n_fail = 0;
  int        cyc = 0;
  cbus_req_t exp_creq;

  // reference model state
  logic      m_last;
  logic      m_sel;
  bit        m_busy;
  int        m_free_at;
  cbus_req_t m_cur;
  int        mem_wait;
  int        mem_beats;

  // core-side driver state
  bit          i_on, d_on, i_cool, d_cool, i_done, d_done, gen_en, found;
  logic [1:0]  force_start;
  logic [31:0] i_addr;
  dbus_req_t   d_pl;
  logic [63:0] rd;
  msize_t      size_tab [4] = '{MSIZE1, MSIZE2, MSIZE4, MSIZE8};

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endfunction

  // Monitor: cbus request every cycle, responses popped from the scoreboard when they appear.
  always @(negedge clk) begin
    exp_t e;
    check("creq", 128'(creq), 128'(exp_creq));
    if (sbq.size() > 0 && sbq[0].due < cyc) begin
      check("resp_missing", 128'(cyc), 128'(sbq[0].due));
      void'(sbq.pop_front());
    end
    if (iresp.data_ok || dresp.data_ok) begin
      if (sbq.size() == 0) begin
        check("resp_unexpected", 128'({iresp.data_ok, dresp.data_ok}), 128'(0));
      end else begin
        e = sbq.pop_front();
        check("resp_cycle", 128'(cyc), 128'(e.due));
        check("resp_data_ok", 128'({iresp.data_ok, dresp.data_ok}), e.port ? 128'(2'b01) : 128'(2'b10));
        check("resp_addr_ok", 128'({iresp.addr_ok, dresp.addr_ok}), e.port ? 128'(2'b01) : 128'(2'b10));
        check("resp_data", e.port ? 128'(dresp.data) : 128'({32'b0, iresp.data}), 128'(e.data));
      end
    end
  end

  task automatic drive_cycle();
    bit start_i, start_d;
    @(posedge clk);
    cyc++;
    #1;
    if (i_done) i_on = 1'b0;
    if (d_done) d_on = 1'b0;
    if (!m_busy && cyc >= m_free_at) begin
      i_cool = 1'b0;
      d_cool = 1'b0;
    end
    if (m_busy && m_sel == 1'b0 && i_on && $urandom_range(0, 15) == 0) begin
      i_on = 1'b0;
      i_cool = 1'b1;
    end
    if (m_busy && m_sel == 1'b1 && d_on && $urandom_range(0, 15) == 0) begin
      d_on = 1'b0;
      d_cool = 1'b1;
    end
    start_i = (force_start != 2'b00) ? force_start[0] : ($urandom_range(0, 2) == 0);
    start_d = (force_start != 2'b00) ? force_start[1] : ($urandom_range(0, 2) == 0);
    force_start = 2'b00;
    if (gen_en && !i_on && !i_cool && start_i) begin
      i_on = 1'b1;
      i_addr = $urandom;
    end
    if (gen_en && !d_on && !d_cool && start_d) begin
      d_on = 1'b1;
      d_pl.addr = $urandom;
      d_pl.size = size_tab[$urandom_range(0, 3)];
      d_pl.strobe = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      d_pl.data = {$urandom, $urandom};
    end
    ireq.valid = i_on;
    ireq.addr = i_addr;
    dreq = d_pl;
    dreq.valid = d_on;
    cresp = '0;
    if (m_busy) begin
      exp_creq = m_cur;
      cresp.data = {$urandom, $urandom};
      if (mem_wait > 0) begin
        mem_wait--;
      end else if (mem_beats > 0) begin
        mem_beats--;
        cresp.ready = 1'b1;
      end else begin
        rd = {$urandom, $urandom};
        cresp.ready = 1'b1;
        cresp.last = 1'b1;
        cresp.data = rd;
        if (m_sel ? d_on : i_on) begin
          sbq.push_back('{port: m_sel,
                          data: m_sel ? rd : {32'b0, (m_cur.addr[2] ? rd[63:32] : rd[31:0])},
                          due: cyc + 1});
        end
        m_busy = 1'b0;
        m_free_at = cyc + 2;
      end
    end else begin
      exp_creq = '0;
      cresp.ready = 1'($urandom_range(0, 1));
      cresp.last = 1'($urandom_range(0, 1));
      cresp.data = {$urandom, $urandom};
    end
    @(negedge clk);
    i_done = iresp.data_ok;
    d_done = dresp.data_ok;
    if (reset && !m_busy && cyc >= m_free_at && (i_on || d_on)) begin
      if (i_on && d_on) begin
        m_sel = ~m_last;
        m_last = m_sel;
      end else begin
        m_sel = d_on;
      end
      m_cur = '0;
      m_cur.valid = 1'b1;
      m_cur.len = MLEN1;
      m_cur.burst = AXI_BURST_FIXED;
      if (m_sel) begin
        m_cur.is_write = (d_pl.strobe != 8'h00);
        m_cur.size = d_pl.size;
        m_cur.addr = d_pl.addr;
        m_cur.strobe = d_pl.strobe;
        m_cur.data = d_pl.data;
      end else begin
        m_cur.size = MSIZE4;
        m_cur.addr = i_addr;
      end
      m_busy = 1'b1;
      mem_wait = $urandom_range(0, 2);
      mem_beats = $urandom_range(0, 2);
    end
  endtask

  task automatic clear_model();
    m_busy = 1'b0;
    m_last = SEL_IBUS;
    m_sel = SEL_IBUS;
    m_free_at = 0;
    sbq.delete();
    i_on = 1'b0; d_on = 1'b0; i_cool = 1'b0; d_cool = 1'b0;
    i_done = 1'b0; d_done = 1'b0;
    exp_creq = '0;
    ireq = '0;
    dreq = '0;
    cresp = '0;
  endtask

  initial begin
    d_pl = '0;
    i_addr = '0;
    m_cur = '0;
    mem_wait = 0;
    mem_beats = 0;
    found = 1'b0;
    gen_en = 1'b1;
    force_start = 2'b11;
    clear_model();
    #1;
    check("rst_creq_valid", 128'(creq.valid), 128'(0));
    check("rst_iresp_ok", 128'({iresp.addr_ok, iresp.data_ok}), 128'(0));
    check("rst_dresp_ok", 128'({dresp.addr_ok, dresp.data_ok}), 128'(0));
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    repeat (600) drive_cycle();

    for (int n = 0; n < 300 && !found; n++) begin
      drive_cycle();
      if (m_busy && exp_creq.valid) found = 1'b1;
    end
    check("reset_window", 128'(found), 128'(1));
    #2 reset = 1'b0;
    #1;
    check("midrst_creq_valid", 128'(creq.valid), 128'(0));
    check("midrst_data_ok", 128'({iresp.data_ok, dresp.data_ok}), 128'(0));
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    force_start = 2'b01;

    repeat (600) drive_cycle();

    gen_en = 1'b0;
    for (int n = 0; n < 80 && (m_busy || sbq.size() > 0 || i_on || d_on); n++) begin
      drive_cycle();
    end
    check("drain", 128'({m_busy, (sbq.size() != 0), i_on, d_on}), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/core_bus_bridge.md
# core_bus_bridge

Sits directly downstream of the core, between its instruction and data buses and the single cache/memory bus. Accepts one request at a time from the core's `ibus` or `dbus`, issues it as a single-beat `cbus` transaction, and returns the response to the originating port. When both ports request at once, a round-robin grant decides which is served.

## Interface
Parameters:
- none. All types come from `common`.

Ports:
- `clk`  input  1  core clock
- `reset`  input  1  asynchronous, active-low reset (0 = reset asserted)
- `ireq`  input  `ibus_req_t`  instruction request from core (`valid`, `addr`)
- `iresp`  output  `ibus_resp_t`  `addr_ok`, `data_ok`, 32-bit `data`
- `dreq`  input  `dbus_req_t`  data request from core (`valid`, `addr`, `size`, `strobe`, `data`)
- `dresp`  output  `dbus_resp_t`  `addr_ok`, `data_ok`, 64-bit `data`
- `creq`  output  `cbus_req_t`  memory-side request
- `cresp`  input  `cbus_resp_t`  memory-side `ready`, `last`, `data`

## Operation
- FSM states:
  - IDLE → ISSUE when `ireq.valid | dreq.valid`. The winning request is latched into `req_q`, with `sel_q` = 0 for ibus and 1 for dbus.
  - ISSUE → DONE when `cresp.ready & cresp.last`. `cresp.data` is latched into `data_q`.
  - DONE → IDLE unconditionally.
- Arbitration happens in IDLE only:
  - If only one port is valid, that port wins.
  - If both are valid, the port not equal to `last_q` wins; `last_q` is then updated to the winner.
  - Reset value of `last_q` is ibus, so dbus wins the first tie.
- `creq` in ISSUE, driven only from `req_q`; `creq` is all-zero in IDLE and DONE:
  - `valid` = 1, `len` = `MLEN1`, `burst` = `AXI_BURST_FIXED`, `addr` = latched addr.
  - ibus request: `is_write` = 0, `size` = `MSIZE4`, `strobe` = 0.
  - dbus request: `is_write` = `|strobe`, with `size`, `strobe` and `data` passed through unchanged.
- Responses in DONE:
  - Only the port selected by `sel_q` sees `addr_ok` = `data_ok` = 1, for exactly one cycle.
  - `iresp.data` = `addr[2] ? data_q[63:32] : data_q[31:0]`.
  - `dresp.data` = `data_q`.
- Outside DONE, both `iresp` and `dresp` are all-zero.
- Protocol rule: the requester holds `valid` and its payload until `data_ok`. The bridge never re-samples a request after latching it.
- If the requester drops `valid` during ISSUE, the `cbus` transaction still completes. Its response pulse in DONE is suppressed when the port's `valid` is 0 in DONE.

## Timing
- Reset, asynchronous: state = IDLE, `req_q` = 0, `data_q` = 0, `last_q` = ibus. Consequently `creq.valid` and all `addr_ok`/`data_ok` outputs are 0 immediately, with no clock edge needed.
- Reset asserted mid-transaction: the transaction is abandoned with no response pulse. After release, the bridge restarts in IDLE.
- Latency, with the request first seen in IDLE at cycle 0:
  - `creq.valid` is high from cycle 1.
  - If `cresp.ready & last` arrives at cycle k ≥ 1, `data_ok` is pulsed at k+1.
  - Minimum round trip is 2 cycles. The next request is arbitrated at k+2.
- `cresp.ready` without `last` in ISSUE: no state change; keep waiting.
- `cresp` is ignored outside ISSUE.
- A request arriving during ISSUE or DONE waits until IDLE. A losing requester is guaranteed service in the next IDLE if it is still valid.
- Back-to-back throughput: one transaction per k+2 cycles.

## Structure
- Add `bridge_state_t` (IDLE, ISSUE, DONE) to `common`.
- The `MSIZE*`, `MLEN*` and `AXI_BURST_*` constants already live in `common`; reuse them.
- Sub-module `rr_arbiter2`: 2-way round-robin with `last_q`, taking a `req[1:0]` / `update` input and producing a `grant` output.
- Instantiated in the top wrapper between `core` and the memory system. The combinational `freq`/`mreq` mux stays inside `core`.

## Test plan
- **Single ibus read:** ireq {1, 0x8000_0004}; memory returns 0x1122334455667788 with ready&last at cycle 3 → `iresp.data_ok` = 1 at cycle 4, data = 0x11223344. `creq.size` = `MSIZE4`, `is_write` = 0.
- **dbus write:** dreq {addr 0x8000_1000, size `MSIZE8`, strobe 0xFF, data 0xDEADBEEF} → `creq.is_write` = 1, strobe 0xFF, same data. `dresp.data_ok` is pulsed one cycle after `cresp.last`. `iresp` stays 0 throughout.
- **Simultaneous requests after reset:** dbus served first, then ibus. Holding both valid for 4 transactions → grant order d, i, d, i.
- **Multi-beat wait:** `cresp.ready` = 1 with `last` = 0 for 2 cycles, then `last` = 1 → exactly one `data_ok` pulse, and it follows the last beat.
- **Reset mid-ISSUE:** `reset` = 0 while `creq.valid` = 1 → `creq.valid` = 0 in the same cycle, no `data_ok` pulse. After release, a fresh ibus request completes normally.
- **Dropped valid:** `ireq.valid` falls during ISSUE → the `cbus` transaction completes, `iresp.data_ok` stays 0, and the FSM returns to IDLE.
